// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: shift-add multiply, restoring divide, WIDTH
// iterations per op, result on the HI/LO pair.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | WIDTH iterations on magnitudes
// FIX   | sign correction, HI/LO written
// DONE  | one-cycle done pulse; start accepted back-to-back
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic               accept;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_top;
  logic               div_fit;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_fix;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & port_a[WIDTH-1];
  assign b_neg     = is_signed & port_b[WIDTH-1];
  assign a_mag     = a_neg ? -port_a : port_a;
  assign b_mag     = b_neg ? -port_b : port_b;

  // Multiply: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

  // Divide: acc = {partial remainder, dividend bits / quotient bits}
  assign div_top = acc[2*WIDTH-1:WIDTH-1];
  assign div_fit = div_top >= {1'b0, opnd};
  assign div_rem = div_fit ? WIDTH'(div_top - {1'b0, opnd}) : div_top[WIDTH-1:0];

  assign acc_next = is_div ? {div_rem, acc[WIDTH-2:0], div_fit}
                           : {mul_sum, acc[WIDTH-1:1]};
  assign prod_fix = neg_q ? -acc : acc;

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state    <= CALC;
            cnt      <= '0;
            is_div   <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= op[1] && (port_b == '0);
            opnd     <= op[1] ? b_mag : a_mag;
            acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= FIX;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          if (is_div) begin
            // Divide by zero leaves |a| as remainder, so hi restores port_a naturally
            hi <= neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
            lo <= div_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed boundary vectors, randomized ops against a
// 64-bit arithmetic reference, start-while-busy, back-to-back issue and reset abort.
module tb_muldiv_unit;

  localparam int LAT = 34;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] port_a = 32'd0;
  logic [31:0] port_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op),
    .port_a(port_a), .port_b(port_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    model = '0;
    if (o[1] && b == 32'd0) model = {a, 32'hFFFF_FFFF};
    else begin
      case (o)
        2'd0: model = sa * sb;
        2'd1: model = {32'd0, a} * {32'd0, b};
        2'd2: begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
        default: model = {a % b, a / b};
      endcase
    end
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(3) == 0) pick_operand = corners[$urandom_range(5)];
    else pick_operand = $urandom;
  endfunction

  // Called at posedge+1; start is sampled on the following edge (cycle 0).
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; port_a = a; port_b = b; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    op = 2'($urandom_range(3)); port_a = $urandom; port_b = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int cyc);
    issue(o, a, b);
    wait_done(cyc);
    res = {hi, lo};
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done});
    end
    n_tests++;
    if ({hi, lo} !== 64'd0) begin
      n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    RST = 1'b0;
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [8];
    logic [31:0] t_a  [8];
    logic [31:0] t_b  [8];
    logic [63:0] t_exp[8];
    logic [63:0] res;
    int cyc;
    t_op  = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    t_a   = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h1234,
              32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    t_b   = '{32'hFFFF_FFFF, 32'h7, 32'h2, 32'd7, 32'h0,
              32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    t_exp = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD,
              64'h0000_0002_0000_000E, 64'h0000_1234_FFFF_FFFF, 64'h0000_0000_8000_0000,
              64'h4000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000};
    for (int i = 0; i < 8; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], res, cyc);
      n_tests++;
      if (cyc !== LAT) begin
        n_fail++; $display("FAIL directed_latency[%0d]: done at cycle %0d expected %0d", i, cyc, LAT);
      end
      n_tests++;
      if (res !== t_exp[i]) begin
        n_fail++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, t_exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    logic [63:0] res, exp;
    int cyc;
    for (int i = 0; i < 60; i++) begin
      o = 2'($urandom_range(3));
      a = pick_operand();
      b = pick_operand();
      exp = model(o, a, b);
      run_op(o, a, b, res, cyc);
      n_tests++;
      if (res !== exp || cyc !== LAT) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h at cycle %0d expected %h at cycle %0d",
                 i, o, a, b, res, cyc, exp, LAT);
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [63:0] prev, exp;
    int cyc, n_done, done_cyc;
    prev = {hi, lo};
    exp = model(2'd2, 32'hDEAD_BEEF, 32'h0000_1357);
    issue(2'd2, 32'hDEAD_BEEF, 32'h0000_1357);
    n_tests++;
    if ({busy, done} !== 2'b10) begin
      n_fail++; $display("FAIL busy_cycle1: busy/done=%b expected 10", {busy, done});
    end
    n_done = 0; done_cyc = 0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      if (done === 1'b1) begin n_done++; done_cyc = cyc; end
      if (cyc == 10) begin
        n_tests++;
        if ({hi, lo} !== prev) begin
          n_fail++; $display("FAIL hold_during_calc: got %h expected %h", {hi, lo}, prev);
        end
      end
      start = (cyc == 5 || cyc == 20);
      op = 2'd1; port_a = 32'd5; port_b = 32'd5;
      @(posedge CLK); #1;
    end
    start = 1'b0;
    n_tests++;
    if (n_done != 1 || done_cyc != LAT) begin
      n_fail++; $display("FAIL ignore_start: %0d done pulses last at cycle %0d, expected 1 at %0d",
                         n_done, done_cyc, LAT);
    end
    n_tests++;
    if ({hi, lo} !== exp) begin
      n_fail++; $display("FAIL ignore_start_result: got %h expected %h", {hi, lo}, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res1, res2, exp1, exp2;
    int cyc1, cyc2;
    exp1 = model(2'd0, 32'h1234_5678, 32'hF000_0001);
    exp2 = model(2'd3, 32'hCAFE_F00D, 32'h0000_0013);
    run_op(2'd0, 32'h1234_5678, 32'hF000_0001, res1, cyc1);
    run_op(2'd3, 32'hCAFE_F00D, 32'h0000_0013, res2, cyc2);
    n_tests++;
    if (res1 !== exp1 || cyc1 !== LAT) begin
      n_fail++; $display("FAIL b2b_first: got %h at cycle %0d expected %h at %0d", res1, cyc1, exp1, LAT);
    end
    n_tests++;
    if (res2 !== exp2 || cyc2 !== LAT) begin
      n_fail++; $display("FAIL b2b_second: got %h at cycle %0d expected %h at %0d", res2, cyc2, exp2, LAT);
    end
    @(posedge CLK); #1;
    n_tests++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== exp2) begin
      n_fail++; $display("FAIL done_pulse_hold: busy/done=%b hilo=%h expected 00 and %h",
                         {busy, done}, {hi, lo}, exp2);
    end
  endtask

  task automatic test_reset_abort();
    logic [63:0] res, exp;
    int cyc, n_done;
    issue(2'd0, 32'h0000_0077, 32'hFFFF_FF00);
    for (cyc = 1; cyc < 10; cyc++) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== 64'd0) begin
      n_fail++; $display("FAIL reset_abort: busy/done=%b hilo=%h expected 00 and 0", {busy, done}, {hi, lo});
    end
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1) n_done++;
      @(posedge CLK); #1;
    end
    n_tests++;
    if (n_done != 0) begin
      n_fail++; $display("FAIL abort_no_done: saw %0d done pulses expected 0", n_done);
    end
    exp = model(2'd2, 32'h8000_0000, 32'h0000_0003);
    run_op(2'd2, 32'h8000_0000, 32'h0000_0003, res, cyc);
    n_tests++;
    if (res !== exp || cyc !== LAT) begin
      n_fail++; $display("FAIL after_reset_op: got %h at cycle %0d expected %h at %0d", res, cyc, exp, LAT);
    end
  endtask

  initial begin
    @(posedge CLK); #1;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
